// File: rtl/bmu_pkg.sv
//------------------------------------------------------------------------------
// Module   : bmu_pkg
// Purpose  : Opcodes, FSM encoding and result-slice helper shared by the BMU
//            and its multi-cycle companion.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package bmu_pkg;

  localparam logic [4:0] c_OPT_CLMUL  = 5'b00001;
  localparam logic [4:0] c_OPT_CLMULH = 5'b00010;
  localparam logic [4:0] c_OPT_CLMULR = 5'b00011;
  localparam logic [4:0] c_OPT_CLZ    = 5'b00100;
  localparam logic [4:0] c_OPT_CPOP   = 5'b00101;
  localparam logic [4:0] c_OPT_CTZ    = 5'b00110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // The 64-bit carry-less product is sliced according to the CLMUL variant.
  function automatic logic [31:0] clmul_slice(input logic [4:0] opt, input logic [63:0] acc);
    case (opt)
      c_OPT_CLMULH: clmul_slice = acc[63:32];
      c_OPT_CLMULR: clmul_slice = acc[62:31];
      default:      clmul_slice = acc[31:0];
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bmu_bitcount.sv
//------------------------------------------------------------------------------
// Module   : bmu_bitcount
// Purpose  : Combinational leading-zero, trailing-zero and population counts
//            of a 32-bit word. A zero input gives clz = ctz = 32.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bmu_bitcount (
  input  logic [31:0] x,
  output logic [5:0]  clz,
  output logic [5:0]  ctz,
  output logic [5:0]  cpop
);

  always_comb begin
    clz  = 6'd32;
    ctz  = 6'd32;
    cpop = 6'd0;
    // Ascending scan: the highest set bit is the last to write clz.
    for (int i = 0; i < 32; i++) begin
      if (x[i]) clz = 6'(31 - i);
      cpop = cpop + {5'd0, x[i]};
    end
    for (int i = 31; i >= 0; i--) begin
      if (x[i]) ctz = 6'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bmu_seq_unit.sv
//------------------------------------------------------------------------------
// Module   : bmu_seq_unit
// Purpose  : Multi-cycle CLMUL/CLMULH/CLMULR/CLZ/CTZ/CPOP beside the BMU,
//            start/done handshake. Define BMU_CLMUL_RADIX4_EN for 2 bits/cycle.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bmu_seq_unit
  import bmu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  option,
  input  logic [31:0] BMU_in_X,
  input  logic [31:0] BMU_in_Y,
  output logic        busy,
  output logic        done,
  output logic [31:0] BMU_out_S
);

`ifdef BMU_CLMUL_RADIX4_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 5;
`endif

  state_t           r_state, w_state_nxt;
  logic [4:0]       r_opt,   w_opt_nxt;
  logic [31:0]      r_y,     w_y_nxt;
  logic [63:0]      r_xs,    w_xs_nxt;
  logic [63:0]      r_acc,   w_acc_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [31:0]      r_res,   w_res_nxt;
  logic [63:0]      w_acc_step;
  logic [5:0]       w_clz, w_ctz, w_cpop;

  bmu_bitcount u_bitcount (
    .x    (BMU_in_X),
    .clz  (w_clz),
    .ctz  (w_ctz),
    .cpop (w_cpop)
  );

  // Multiplicand is pre-shifted and Y consumed from the LSB, so no barrel shifter.
`ifdef BMU_CLMUL_RADIX4_EN
  assign w_acc_step = r_acc ^ (r_y[0] ? r_xs : 64'd0) ^ (r_y[1] ? (r_xs << 1) : 64'd0);
`else
  assign w_acc_step = r_acc ^ (r_y[0] ? r_xs : 64'd0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_opt_nxt   = r_opt;
    w_y_nxt     = r_y;
    w_xs_nxt    = r_xs;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_opt_nxt = option;
          w_y_nxt   = BMU_in_Y;
          w_xs_nxt  = {32'd0, BMU_in_X};
          w_acc_nxt = 64'd0;
          w_cnt_nxt = '0;
          case (option)
            c_OPT_CLMUL, c_OPT_CLMULH, c_OPT_CLMULR: w_state_nxt = S_RUN;
            c_OPT_CLZ:  begin w_res_nxt = {26'd0, w_clz};  w_state_nxt = S_FIN; end
            c_OPT_CTZ:  begin w_res_nxt = {26'd0, w_ctz};  w_state_nxt = S_FIN; end
            c_OPT_CPOP: begin w_res_nxt = {26'd0, w_cpop}; w_state_nxt = S_FIN; end
            default:    begin w_res_nxt = BMU_in_X;        w_state_nxt = S_FIN; end
          endcase
        end
      end
      S_RUN: begin
        w_acc_nxt = w_acc_step;
        w_cnt_nxt = r_cnt + 1'b1;
`ifdef BMU_CLMUL_RADIX4_EN
        w_xs_nxt  = r_xs << 2;
        w_y_nxt   = r_y >> 2;
`else
        w_xs_nxt  = r_xs << 1;
        w_y_nxt   = r_y >> 1;
`endif
        if (&r_cnt) begin
          w_res_nxt   = clmul_slice(r_opt, w_acc_step);
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Flush wins over everything except reset, and never disturbs the result.
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_res_nxt   = r_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_opt   <= 5'd0;
      r_y     <= 32'd0;
      r_xs    <= 64'd0;
      r_acc   <= 64'd0;
      r_cnt   <= '0;
      r_res   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_opt   <= w_opt_nxt;
      r_y     <= w_y_nxt;
      r_xs    <= w_xs_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign BMU_out_S = r_res;

endmodule

`default_nettype wire

// File: tb/tb_bmu_seq_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_bmu_seq_unit
// Purpose  : Self-checking bench for bmu_seq_unit: directed vector table,
//            multi-cycle corner sequences and randomized reference checks.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bmu_seq_unit;

`ifdef BMU_CLMUL_RADIX4_EN
  localparam int CL_LAT = 17;
`else
  localparam int CL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [4:0]  option;
  logic [31:0] BMU_in_X, BMU_in_Y;
  logic        busy, done;
  logic [31:0] BMU_out_S;

  int checks = 0;
  int errors = 0;

  bmu_seq_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .option    (option),
    .BMU_in_X  (BMU_in_X),
    .BMU_in_Y  (BMU_in_Y),
    .busy      (busy),
    .done      (done),
    .BMU_out_S (BMU_out_S)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  opt;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic logic [31:0] ref_model(input logic [4:0] opt, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int n;
    p = 64'd0;
    for (int i = 0; i < 32; i++) if (y[i]) p = p ^ ({32'd0, x} << i);
    case (opt)
      5'd1: return p[31:0];
      5'd2: return p[63:32];
      5'd3: return p[62:31];
      5'd4: begin n = 0; while (n < 32 && !x[31-n]) n++; return 32'(n); end
      5'd5: return 32'($countones(x));
      5'd6: begin n = 0; while (n < 32 && !x[n]) n++; return 32'(n); end
      default: return x;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] opt);
    return (opt >= 5'd1 && opt <= 5'd3) ? CL_LAT : 1;
  endfunction

  // Called at posedge+1 in IDLE; returns at posedge+1 one cycle after done.
  task automatic run_op(input string name, input logic [4:0] opt, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
    int cyc, lat;
    bit busy_ok, seen;
    logic [31:0] res;
    option = opt; BMU_in_X = x; BMU_in_Y = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; seen = 0; busy_ok = 1; lat = -1; res = 32'hxxxxxxxx;
    while (!seen && cyc <= 100) begin
      if (!busy) busy_ok = 0;
      if (done) begin
        seen = 1; lat = cyc; res = BMU_out_S;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    chk({name, "_result"}, res, exp);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat(opt)));
    chk({name, "_busy_window"}, {31'd0, busy_ok}, 32'd1);
    @(posedge clk); #1;
    chk({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] prior, res1;
    int ndone, bad;
    logic [4:0] ropt;
    logic [31:0] rx, ry;

    tbl[0]  = '{5'd1, 32'h00000003, 32'h00000003, 32'h00000005};
    tbl[1]  = '{5'd2, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[2]  = '{5'd3, 32'h80000000, 32'h80000000, 32'h80000000};
    tbl[3]  = '{5'd1, 32'h80000000, 32'h80000000, 32'h00000000};
    tbl[4]  = '{5'd4, 32'h00010000, 32'h0,        32'd15};
    tbl[5]  = '{5'd6, 32'h00010000, 32'h0,        32'd16};
    tbl[6]  = '{5'd5, 32'hF0F0F0F0, 32'h0,        32'd16};
    tbl[7]  = '{5'd4, 32'h00000000, 32'h0,        32'd32};
    tbl[8]  = '{5'd6, 32'h00000000, 32'h0,        32'd32};
    tbl[9]  = '{5'd5, 32'hFFFFFFFF, 32'h0,        32'd32};
    tbl[10] = '{5'd0, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    option = 5'd0; BMU_in_X = 32'd0; BMU_in_Y = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, BMU_out_S[29:0]}, 32'd0);
    chk("reset_out", BMU_out_S, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), tbl[i].opt, tbl[i].x, tbl[i].y, tbl[i].exp);

    // Abort in cycle 5 of a CLMUL: no done, result untouched, then a fresh CPOP.
    prior = BMU_out_S;
    option = 5'd1; BMU_in_X = 32'h1234ABCD; BMU_in_Y = 32'hFFFF0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_busy_low", {31'd0, busy}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) ndone++;
      if (BMU_out_S !== prior) ndone++;
      @(posedge clk); #1;
    end
    chk("abort_no_done_out_kept", 32'(ndone), 32'd0);
    run_op("abort_then_cpop", 5'd5, 32'h0F0F00FF, 32'h0, 32'd16);

    // Start while busy: second start in cycle 3 is ignored.
    res1 = ref_model(5'd2, 32'hCAFEF00D, 32'h8badf00d);
    option = 5'd2; BMU_in_X = 32'hCAFEF00D; BMU_in_Y = 32'h8BADF00D; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0; prior = 32'd0;
    for (int c = 1; c <= CL_LAT + 6; c++) begin
      if (done) begin ndone++; prior = BMU_out_S; end
      if (c == 3) begin
        option = 5'd4; BMU_in_X = 32'h1; BMU_in_Y = 32'h0; start = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy_start_one_done", 32'(ndone), 32'd1);
    chk("busy_start_result", prior, res1);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // Reset mid-RUN.
    option = 5'd1; BMU_in_X = 32'hFFFFFFFF; BMU_in_Y = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("midrun_reset", {30'd0, busy, done}, 32'd0);
    chk("midrun_reset_out", BMU_out_S, 32'd0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 30; n++) begin
      bad = $urandom_range(0, 9);
      ropt = (bad < 7) ? 5'(bad) : 5'($urandom_range(7, 31));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 7) == 0) rx = 32'd0;
      run_op($sformatf("rand%0d_op%0d", n, ropt), ropt, rx, ry, ref_model(ropt, rx, ry));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bmu_seq_unit.md
# bmu_seq_unit

Multi-cycle companion to the bit-manipulation unit. It executes the Zbc/Zbb operations the combinational BMU does not handle: CLMUL, CLMULH, CLMULR, CLZ, CTZ and CPOP. It sits beside the BMU in the execute stage and receives the same decoded `option` and operands. It returns its result through a start/done handshake, and the pipeline stalls on `busy`.

## Interface
- No parameters. Width is fixed at 32; the option encoding comes from the shared package.
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  launch an operation; sampled only when `busy`=0
- `abort`  in  1  pipeline flush; kills any in-flight operation
- `option`  in  5  BMU opcode: CLMUL=00001, CLMULH=00010, CLMULR=00011, CLZ=00100, CPOP=00101, CTZ=00110
- `BMU_in_X`  in  32  rs1 operand
- `BMU_in_Y`  in  32  rs2 operand (CLMUL* only)
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse; `BMU_out_S` is valid in this cycle
- `BMU_out_S`  out  32  result; held until the next `done`

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
  - FIN: `busy`=1 and `done`=1 for exactly one cycle, then IDLE.
- IDLE with `start`=1 and `abort`=0:
  - Latch `option`, X and Y.
  - CLMUL*: clear the 64-bit accumulator and the step counter, then go to RUN.
  - CLZ/CTZ/CPOP: compute combinationally from X, register the result, go to FIN.
  - Any other option: register X unchanged (matches the BMU default), go to FIN.
- RUN, each cycle, for each Y bit k handled that cycle: if Y[k]=1, `acc ^= {32'b0,X} << k`.
  - The counter advances each cycle.
  - The last step goes to FIN with the selected result registered.
- CLMUL result slices:
  - CLMUL returns acc[31:0].
  - CLMULH returns acc[63:32].
  - CLMULR returns acc[62:31].
- Count results:
  - CLZ(0)=32 and CTZ(0)=32.
  - CPOP ranges 0..32.
  - All counts are zero-extended to 32 bits.
- `start` while `busy`=1 is ignored; there is no queueing.
- `abort`=1 in any state: the next state is IDLE, no `done` is produced, and `BMU_out_S` keeps its previous value. `abort` beats a simultaneous `start`.
- `rst`=1 beats everything: state IDLE, `busy`=0, `done`=0, `BMU_out_S`=0, accumulator and counter cleared.

## Timing
- "Cycle 0" is the cycle in which `start` is sampled high in IDLE.
- CLZ/CTZ/CPOP/other: `busy` and `done` are high in cycle 1. Latency is 1, and a new `start` is accepted in cycle 2.
- CLMUL* with radix-4 (2 Y bits per cycle):
  - RUN occupies cycles 1–16.
  - `done` is high in cycle 17.
- CLMUL* with radix-2 (1 Y bit per cycle):
  - RUN occupies cycles 1–32.
  - `done` is high in cycle 33.
- `busy` rises in cycle 1 and falls after the FIN cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `BMU_CLMUL_RADIX4_EN` defined:
  - Two Y bits per RUN cycle, using two XOR-shift terms.
  - 4-bit counter, 16 RUN cycles.
- Not defined:
  - One Y bit per cycle.
  - 5-bit counter, 32 RUN cycles.
- Results are bit-identical in both configurations; only latency changes.
- The whole module stays inside the existing `ENABLE_BMU` guard.

## Structure
- Shared package `bmu_pkg` holds:
  - the 5-bit option localparams used by both BMU and this block;
  - the state encoding (IDLE/RUN/FIN).
- One sub-module: `bmu_bitcount`, combinational, 32-bit input, producing clz/ctz/cpop (6 bits each). The top level selects among them by option.
- The CLMUL accumulator, counter and FSM live in the top module.

## Test plan
- CLMUL, X=0x00000003, Y=0x00000003:
  - `BMU_out_S`=0x00000005.
  - `done` in cycle 17 with radix-4, cycle 33 with radix-2.
  - `busy` is high from cycle 1 through the `done` cycle.
- X=0x80000000, Y=0x80000000:
  - CLMULH gives 0x40000000.
  - CLMULR gives 0x80000000.
  - CLMUL gives 0x00000000.
- Counts, each with `done` in cycle 1:
  - X=0x00010000: CLZ=15, CTZ=16.
  - CPOP(0xF0F0F0F0)=16.
  - CLZ(0)=32, CTZ(0)=32, CPOP(0xFFFFFFFF)=32.
- Abort: `abort` pulsed in cycle 5 of a CLMUL.
  - `busy`=0 from cycle 6, no `done`.
  - `BMU_out_S` keeps the prior result.
  - A fresh CPOP started immediately returns the correct count.
- Start while busy: a second `start` in cycle 3 of a CLMUL is ignored, and exactly one `done` pulse carries the first result.
- Reset mid-RUN: `rst` high for one cycle, then `busy`=0, `done`=0 and `BMU_out_S`=0 in the next cycle.
